// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer compare-value sequencer: register map,
// SEQ_CTRL field positions, FSM encoding and address-decode helpers.
package timer_seq_pkg;

   localparam int DATA_W    = 32;
   localparam int SEQ_DEPTH = 8;
   localparam int IDX_W     = 3;

   localparam logic [7:0] SEQ_CTRL_ADDR = 8'h00;
   localparam logic [7:0] TAB_BASE_ADDR = 8'h10;
   localparam logic [7:0] TAB_LAST_ADDR = 8'h2C;
   localparam logic [7:0] TMR_CMPO_ADDR = 8'h04;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_LOOP     = 1;
   localparam int CTRL_LAST_LSB = 2;
   localparam int CTRL_IDX_LSB  = 5;
   localparam int CTRL_BUSY     = 8;
   localparam int CTRL_DONE     = 9;
   localparam int CTRL_IRQ_EN   = 10;
   localparam int CTRL_OVR      = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_WAIT_OF = 2'd2
   } seq_state_e;

   // True for word-aligned offsets 0x10..0x2C (the eight table entries).
   function automatic logic is_tab_addr(input logic [7:0] a);
      return (a >= TAB_BASE_ADDR) && (a <= TAB_LAST_ADDR) && (a[1:0] == 2'b00);
   endfunction

   // Table index of a table offset; only meaningful when is_tab_addr() holds.
   function automatic logic [IDX_W-1:0] tab_idx(input logic [7:0] a);
      return IDX_W'((a - TAB_BASE_ADDR) >> 2);
   endfunction

endpackage

// File: rtl/timer_seq_tab.sv
// 8 x 32 compare-word table: one byte-enabled write port, one async read
// port for the CPU bus and one async read port for the sequencer fetch.
module timer_seq_tab
   import timer_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wsel,
   input  logic [IDX_W-1:0]  bus_raddr,
   output logic [DATA_W-1:0] bus_rdata,
   input  logic [IDX_W-1:0]  seq_raddr,
   output logic [DATA_W-1:0] seq_rdata
);

   logic [DATA_W-1:0] mem [SEQ_DEPTH];

   // Table storage: cleared on reset, byte-lane writes from the CPU bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SEQ_DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wsel[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign bus_rdata = mem[bus_raddr];
   assign seq_rdata = mem[seq_raddr];

endmodule

// File: rtl/timer_seq.sv
// Timer compare-value sequencer. Steps through the CMPO table, writing one
// entry into the timer per overflow, and merges those writes with CPU timer
// writes (the CPU always wins the timer port).
module timer_seq
   import timer_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   input  logic [7:0]  raddr_i,
   input  logic        rd_i,
   output logic [31:0] data_o,
   input  logic [7:0]  cpu_tmr_waddr_i,
   input  logic [31:0] cpu_tmr_data_i,
   input  logic [3:0]  cpu_tmr_sel_i,
   input  logic        cpu_tmr_we_i,
   output logic [7:0]  tmr_waddr_o,
   output logic [31:0] tmr_data_o,
   output logic [3:0]  tmr_sel_o,
   output logic        tmr_we_o,
   input  logic        tmr_of_i,
   output logic        irq_seq_o
);

   seq_state_e        state;
   logic              en;
   logic              loop;
   logic [IDX_W-1:0]  last;
   logic [IDX_W-1:0]  idx;
   logic              done;
   logic              irq_en;
   logic              ovr;
   logic              pend;

   logic              ctrl_wr;
   logic              wr_b0;
   logic              wr_b1;
   logic              en_wr0;
   logic              en_wr1;
   logic              of_evt;
   logic              seq_fin;
   logic              tab_we;
   logic [DATA_W-1:0] tab_bus_rdata;
   logic [DATA_W-1:0] tab_seq_rdata;
   logic [DATA_W-1:0] ctrl_word;
   logic [DATA_W-1:0] rd_word;

   assign tab_we = we_i && is_tab_addr(waddr_i);

   timer_seq_tab u_tab (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (tab_we),
      .waddr     (tab_idx(waddr_i)),
      .wdata     (data_i),
      .wsel      (sel_i),
      .bus_raddr (tab_idx(raddr_i)),
      .bus_rdata (tab_bus_rdata),
      .seq_raddr (idx),
      .seq_rdata (tab_seq_rdata)
   );

   // Decode CPU control writes and the overflow/completion conditions.
   always_comb begin
      ctrl_wr = we_i && (waddr_i == SEQ_CTRL_ADDR);
      wr_b0   = ctrl_wr && sel_i[0];
      wr_b1   = ctrl_wr && sel_i[1];
      en_wr0  = wr_b0 && !data_i[CTRL_EN];
      en_wr1  = wr_b0 && data_i[CTRL_EN];
      of_evt  = tmr_of_i || pend;
      seq_fin = (state == ST_WAIT_OF) && of_evt && (idx >= last) && !loop;
   end

   // Sequencer FSM, control/status register and merged timer write port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         en          <= 1'b0;
         loop        <= 1'b0;
         last        <= '0;
         idx         <= '0;
         done        <= 1'b0;
         irq_en      <= 1'b0;
         ovr         <= 1'b0;
         pend        <= 1'b0;
         tmr_waddr_o <= '0;
         tmr_data_o  <= '0;
         tmr_sel_o   <= '0;
         tmr_we_o    <= 1'b0;
         irq_seq_o   <= 1'b0;
      end else begin
         irq_seq_o <= 1'b0;
         tmr_we_o  <= 1'b0;

         // A CPU timer write always takes the port; the sequencer write
         // is withheld when the same edge disables the sequencer.
         if (cpu_tmr_we_i) begin
            tmr_waddr_o <= cpu_tmr_waddr_i;
            tmr_data_o  <= cpu_tmr_data_i;
            tmr_sel_o   <= cpu_tmr_sel_i;
            tmr_we_o    <= 1'b1;
         end else if ((state == ST_LOAD) && !en_wr0) begin
            tmr_waddr_o <= TMR_CMPO_ADDR;
            tmr_data_o  <= tab_seq_rdata;
            tmr_sel_o   <= 4'hF;
            tmr_we_o    <= 1'b1;
         end

         // CPU field writes first so that hardware sticky sets below win.
         if (wr_b0) begin
            loop <= data_i[CTRL_LOOP];
            last <= data_i[CTRL_LAST_LSB +: IDX_W];
         end
         if (wr_b1) begin
            irq_en <= data_i[CTRL_IRQ_EN];
            if (data_i[CTRL_DONE]) done <= 1'b0;
            if (data_i[CTRL_OVR])  ovr  <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
            end
            ST_LOAD: begin
               if (tmr_of_i) begin
                  if (pend) ovr  <= 1'b1;
                  else      pend <= 1'b1;
               end
               if (!cpu_tmr_we_i) state <= ST_WAIT_OF;
            end
            ST_WAIT_OF: begin
               if (of_evt) begin
                  pend <= 1'b0;
                  if (tmr_of_i && pend) ovr <= 1'b1;
                  if (idx < last) begin
                     idx   <= idx + IDX_W'(1);
                     state <= ST_LOAD;
                  end else if (loop) begin
                     idx   <= '0;
                     state <= ST_LOAD;
                  end else begin
                     done      <= 1'b1;
                     irq_seq_o <= irq_en;
                     en        <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         // EN writes override the FSM; EN=1 while running (and not just
         // finishing) leaves the sequence untouched.
         if (en_wr0) begin
            en    <= 1'b0;
            pend  <= 1'b0;
            state <= ST_IDLE;
         end else if (en_wr1 && ((state == ST_IDLE) || seq_fin)) begin
            en    <= 1'b1;
            pend  <= 1'b0;
            idx   <= '0;
            state <= ST_LOAD;
         end
      end
   end

   // Assemble the SEQ_CTRL read value and the bus read mux.
   always_comb begin
      ctrl_word                            = '0;
      ctrl_word[CTRL_EN]                   = en;
      ctrl_word[CTRL_LOOP]                 = loop;
      ctrl_word[CTRL_LAST_LSB +: IDX_W]    = last;
      ctrl_word[CTRL_IDX_LSB +: IDX_W]     = idx;
      ctrl_word[CTRL_BUSY]                 = (state != ST_IDLE);
      ctrl_word[CTRL_DONE]                 = done;
      ctrl_word[CTRL_IRQ_EN]               = irq_en;
      ctrl_word[CTRL_OVR]                  = ovr;
      rd_word = '0;
      if (raddr_i == SEQ_CTRL_ADDR)  rd_word = ctrl_word;
      else if (is_tab_addr(raddr_i)) rd_word = tab_bus_rdata;
   end

   // Registered read data, held while no read is requested.
   always_ff @(posedge clk) begin
      if (!rst_n)    data_o <= '0;
      else if (rd_i) data_o <= rd_word;
   end

endmodule

// File: tb/tb_timer_seq.sv
// Directed bench for timer_seq: reset, single-shot, loop, arbitration,
// overrun, disable and mid-run reset scenarios.
module tb_timer_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  waddr_i = '0;
   logic [31:0] data_i = '0;
   logic [3:0]  sel_i = '0;
   logic        we_i = 1'b0;
   logic [7:0]  raddr_i = '0;
   logic        rd_i = 1'b0;
   logic [31:0] data_o;
   logic [7:0]  cpu_tmr_waddr_i = '0;
   logic [31:0] cpu_tmr_data_i = '0;
   logic [3:0]  cpu_tmr_sel_i = '0;
   logic        cpu_tmr_we_i = 1'b0;
   logic [7:0]  tmr_waddr_o;
   logic [31:0] tmr_data_o;
   logic [3:0]  tmr_sel_o;
   logic        tmr_we_o;
   logic        tmr_of_i = 1'b0;
   logic        irq_seq_o;

   int checks = 0;
   int errors = 0;
   int irq_cnt = 0;

   localparam logic [31:0] T0 = 32'h0010_0005;
   localparam logic [31:0] T1 = 32'h0020_0008;
   localparam logic [31:0] T2 = 32'h0030_000C;

   timer_seq dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .waddr_i         (waddr_i),
      .data_i          (data_i),
      .sel_i           (sel_i),
      .we_i            (we_i),
      .raddr_i         (raddr_i),
      .rd_i            (rd_i),
      .data_o          (data_o),
      .cpu_tmr_waddr_i (cpu_tmr_waddr_i),
      .cpu_tmr_data_i  (cpu_tmr_data_i),
      .cpu_tmr_sel_i   (cpu_tmr_sel_i),
      .cpu_tmr_we_i    (cpu_tmr_we_i),
      .tmr_waddr_o     (tmr_waddr_o),
      .tmr_data_o      (tmr_data_o),
      .tmr_sel_o       (tmr_sel_o),
      .tmr_we_o        (tmr_we_o),
      .tmr_of_i        (tmr_of_i),
      .irq_seq_o       (irq_seq_o)
   );

   always #5 clk = ~clk;

   // Count interrupt pulses away from the active edge.
   always @(negedge clk) if (irq_seq_o) irq_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      waddr_i = a; data_i = d; sel_i = 4'hF; we_i = 1'b1;
      tick();
      we_i = 1'b0; sel_i = 4'h0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      raddr_i = a; rd_i = 1'b1;
      tick();
      rd_i = 1'b0;
      d = data_o;
   endtask

   task automatic of_pulse();
      tmr_of_i = 1'b1;
      tick();
      tmr_of_i = 1'b0;
   endtask

   task automatic chk_seq_wr(input string tag, input logic [31:0] exp);
      chk({tag, "_we"}, 32'(tmr_we_o), 32'd1);
      chk({tag, "_addr"}, 32'(tmr_waddr_o), 32'h04);
      chk({tag, "_data"}, tmr_data_o, exp);
      chk({tag, "_sel"}, 32'(tmr_sel_o), 32'hF);
   endtask

   initial begin
      logic [31:0] rd;
      int irq_base;
      int wr_cnt;

      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_we", 32'(tmr_we_o), 32'd0);
      chk("rst_data", tmr_data_o, 32'd0);
      chk("rst_irq", 32'(irq_seq_o), 32'd0);
      chk("rst_rdata", data_o, 32'd0);
      rst_n = 1'b1;
      tick();
      bus_rd(8'h00, rd);
      chk("rst_ctrl", rd, 32'd0);

      // Table setup and readback
      bus_wr(8'h10, T0);
      bus_wr(8'h14, T1);
      bus_wr(8'h18, T2);
      bus_rd(8'h18, rd);
      chk("tab2_rd", rd, T2);
      tick();
      chk("rd_hold", data_o, T2);
      bus_rd(8'h30, rd);
      chk("unmapped_rd", rd, 32'd0);

      // Single-shot: LAST=2, IRQ_EN=1, EN=1
      irq_base = irq_cnt;
      bus_wr(8'h00, 32'h0000_0409);
      chk("ss_lat0", 32'(tmr_we_o), 32'd0);
      tick();
      chk_seq_wr("ss_w0", T0);
      tick();
      chk("ss_we_1cyc", 32'(tmr_we_o), 32'd0);
      of_pulse();
      chk("ss_of_lat", 32'(tmr_we_o), 32'd0);
      tick();
      chk_seq_wr("ss_w1", T1);
      tick();
      of_pulse();
      tick();
      chk_seq_wr("ss_w2", T2);
      tick();
      of_pulse();
      chk("ss_irq", 32'(irq_seq_o), 32'd1);
      tick();
      chk("ss_irq_off", 32'(irq_seq_o), 32'd0);
      chk("ss_irq_cnt", 32'(irq_cnt - irq_base), 32'd1);
      bus_rd(8'h00, rd);
      chk("ss_ctrl", rd, 32'h0000_0648);
      bus_wr(8'h00, 32'h0000_0200);
      bus_rd(8'h00, rd);
      chk("done_w1c", rd, 32'h0000_0040);

      // Loop mode: LAST=1, LOOP=1, IRQ_EN=1
      irq_base = irq_cnt;
      bus_wr(8'h00, 32'h0000_0407);
      tick();
      chk_seq_wr("lp_w0", T0);
      for (int k = 0; k < 5; k++) begin
         tick();
         of_pulse();
         tick();
         chk_seq_wr($sformatf("lp_of%0d", k), (k % 2 == 0) ? T1 : T0);
      end
      tick();
      tick();
      chk("lp_no_irq", 32'(irq_cnt - irq_base), 32'd0);
      bus_wr(8'h00, 32'h0000_0000);
      bus_rd(8'h00, rd);
      chk("lp_stop_ctrl", rd, 32'h0000_0020);

      // Arbitration: LAST=2, LOOP=1, CPU blocks LOAD for 3 cycles
      bus_wr(8'h00, 32'h0000_000B);
      cpu_tmr_we_i = 1'b1; cpu_tmr_waddr_i = 8'h08; cpu_tmr_sel_i = 4'h3;
      for (int k = 0; k < 3; k++) begin
         cpu_tmr_data_i = 32'hA000_0000 + 32'(k);
         tick();
         chk($sformatf("arb_cpu%0d_data", k), tmr_data_o, 32'hA000_0000 + 32'(k));
         chk($sformatf("arb_cpu%0d_addr", k), {tmr_we_o, 8'h0, tmr_sel_o, 11'h0, tmr_waddr_o},
             {1'b1, 8'h0, 4'h3, 11'h0, 8'h08});
      end
      cpu_tmr_we_i = 1'b0;
      tick();
      chk_seq_wr("arb_seq", T0);
      tick();

      // Overrun: two overflows while LOAD is CPU-blocked
      cpu_tmr_we_i = 1'b1; cpu_tmr_data_i = 32'h5555_0000;
      tmr_of_i = 1'b1;
      tick();
      tick();
      tmr_of_i = 1'b0;
      tick();
      tmr_of_i = 1'b1;
      tick();
      tmr_of_i = 1'b0;
      chk("ovr_cpu_pass", tmr_data_o, 32'h5555_0000);
      cpu_tmr_we_i = 1'b0;
      tick();
      chk_seq_wr("ovr_w1", T1);
      tick();
      chk("ovr_pend_lat", 32'(tmr_we_o), 32'd0);
      tick();
      chk_seq_wr("ovr_w2", T2);
      wr_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (tmr_we_o) wr_cnt++;
      end
      chk("ovr_no_extra", 32'(wr_cnt), 32'd0);
      bus_rd(8'h00, rd);
      chk("ovr_ctrl", rd, 32'h0000_094B);
      bus_wr(8'h00, 32'h0000_080B);
      bus_rd(8'h00, rd);
      chk("ovr_w1c", rd, 32'h0000_014B);

      // Disable during LOAD
      cpu_tmr_we_i = 1'b1; cpu_tmr_data_i = 32'h7777_0000;
      tmr_of_i = 1'b1;
      tick();
      tmr_of_i = 1'b0;
      cpu_tmr_we_i = 1'b0;
      bus_wr(8'h00, 32'h0000_0000);
      chk("dis_no_wr", 32'(tmr_we_o), 32'd0);
      bus_rd(8'h00, rd);
      chk("dis_ctrl", rd, 32'h0000_0000);
      wr_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (tmr_we_o) wr_cnt++;
      end
      chk("dis_no_later_wr", 32'(wr_cnt), 32'd0);
      bus_rd(8'h40, rd);
      chk("rd_0x40", rd, 32'd0);

      // Reset mid-run during WAIT_OF
      bus_wr(8'h00, 32'h0000_040B);
      tick();
      chk_seq_wr("mr_w0", T0);
      bus_rd(8'h10, rd);
      chk("mr_tab0", rd, T0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mr_we", 32'(tmr_we_o), 32'd0);
      chk("mr_port", {tmr_waddr_o, 20'h0, tmr_sel_o}, 32'd0);
      chk("mr_data", tmr_data_o, 32'd0);
      chk("mr_irq", 32'(irq_seq_o), 32'd0);
      chk("mr_rdata", data_o, 32'd0);
      bus_rd(8'h00, rd);
      chk("mr_ctrl", rd, 32'd0);
      bus_rd(8'h10, rd);
      chk("mr_tab0_clr", rd, 32'd0);
      tick();
      chk("mr_idle_we", 32'(tmr_we_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
